// File: rtl/matmul_mem_ctrl.sv
// Initiator for a 4-port data memory: reads an M/K/N header and computes C = A x B with one MAC.
// Define READBACK_CHECK_EN to re-read each written C element through port 3 and flag mismatches.
module matmul_mem_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int HDR_BASE = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              write_en0,
  output logic              write_en1,
  output logic              write_en2,
  output logic              write_en3,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3,
  output logic [DATA_W-1:0] datain0,
  output logic [DATA_W-1:0] datain1,
  output logic [DATA_W-1:0] datain2,
  output logic [DATA_W-1:0] datain3,
  input  logic [DATA_W-1:0] dataout0,
  input  logic [DATA_W-1:0] dataout1,
  input  logic [DATA_W-1:0] dataout2,
  input  logic [DATA_W-1:0] dataout3
);
  localparam int AW2 = 2*ADDR_W + 2;
  typedef logic [AW2-1:0] wide_t;
  localparam logic [DATA_W-1:0] DIM_MAX  = DATA_W'((1 << ADDR_W) - 1);
  localparam wide_t             ADDR_MAX = wide_t'((1 << ADDR_W) - 1);
  localparam wide_t             A_BASE   = wide_t'(HDR_BASE + 3);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR_REQ, S_HDR_WAIT, S_CHECK, S_MAC, S_DRAIN, S_WRITE, S_RB, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_q, m_d, k_q, k_d, n_q, n_d, acc_q, acc_d;
  logic [ADDR_W-1:0] i_q, i_d, j_q, j_d, kc_q, kc_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic              error_q, error_d;

  wide_t             m_w, k_w, n_w, b_base, c_base, c_last;
  logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
  logic [DATA_W-1:0] prod;
  logic              dim_zero, dim_big, last_k, last_elem;

`ifdef READBACK_CHECK_EN
  logic [ADDR_W-1:0] rb_addr_q, rb_addr_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_pend_q, rb_pend_d, last_q, last_d;
`else
  logic unused_rb;
  assign unused_rb = ^dataout3;
`endif

  // Dimensions above 2^ADDR_W-1 are rejected up front, so 2*ADDR_W+2 bits hold every sum below.
  always_comb begin
    m_w       = wide_t'(m_q);
    k_w       = wide_t'(k_q);
    n_w       = wide_t'(n_q);
    b_base    = A_BASE + m_w * k_w;
    c_base    = b_base + k_w * n_w;
    c_last    = c_base + m_w * n_w - wide_t'(1);
    a_addr    = ADDR_W'(A_BASE + wide_t'(i_q) * k_w + wide_t'(kc_q));
    b_addr    = ADDR_W'(b_base + wide_t'(kc_q) * n_w + wide_t'(j_q));
    c_addr    = ADDR_W'(c_base + wide_t'(i_q) * n_w + wide_t'(j_q));
    prod      = dataout0 * dataout1;
    dim_zero  = (m_q == '0) || (k_q == '0) || (n_q == '0);
    dim_big   = (m_q > DIM_MAX) || (k_q > DIM_MAX) || (n_q > DIM_MAX);
    last_k    = (kc_q == k_q[ADDR_W-1:0] - ADDR_W'(1));
    last_elem = (i_q == m_q[ADDR_W-1:0] - ADDR_W'(1)) && (j_q == n_q[ADDR_W-1:0] - ADDR_W'(1));
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    state_d   = state_q;
    m_d       = m_q;
    k_d       = k_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    kc_d      = kc_q;
    acc_d     = acc_q;
    error_d   = error_q;
    addr0_d   = addr0_q;
    addr1_d   = addr1_q;
    busy      = 1'b1;
    done      = 1'b0;
    write_en2 = 1'b0;
    addr2     = '0;
    datain2   = '0;
    write_en3 = 1'b0;
    addr3     = '0;
`ifdef READBACK_CHECK_EN
    rb_addr_d = rb_addr_q;
    rb_data_d = rb_data_q;
    rb_pend_d = 1'b0;
    last_d    = last_q;
    if (rb_pend_q && (dataout3 != rb_data_q)) error_d = 1'b1;
`endif
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = S_HDR_REQ;
          error_d = 1'b0;
        end
      end
      S_HDR_REQ: begin
        addr0_d = ADDR_W'(HDR_BASE);
        addr1_d = ADDR_W'(HDR_BASE + 1);
        addr2   = ADDR_W'(HDR_BASE + 2);
        state_d = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        m_d     = dataout0;
        k_d     = dataout1;
        n_d     = dataout2;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dim_zero || dim_big || (c_last > ADDR_MAX)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d     = '0;
          j_d     = '0;
          kc_d    = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        addr0_d = a_addr;
        addr1_d = b_addr;
        kc_d    = kc_q + ADDR_W'(1);
        // Read data lags the address by one cycle, so the first MAC cycle has nothing to add.
        if (kc_q != '0) acc_d = acc_q + prod;
        if (last_k) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d   = acc_q + prod;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        write_en2 = 1'b1;
        addr2     = c_addr;
        datain2   = acc_q;
        kc_d      = '0;
        acc_d     = '0;
        if (j_q == n_q[ADDR_W-1:0] - ADDR_W'(1)) begin
          j_d = '0;
          i_d = i_q + ADDR_W'(1);
        end else begin
          j_d = j_q + ADDR_W'(1);
        end
`ifdef READBACK_CHECK_EN
        rb_addr_d = c_addr;
        rb_data_d = acc_q;
        last_d    = last_elem;
        state_d   = S_RB;
`else
        state_d   = last_elem ? S_DONE : S_MAC;
`endif
      end
`ifdef READBACK_CHECK_EN
      S_RB: begin
        addr3     = rb_addr_q;
        rb_pend_d = 1'b1;
        state_d   = last_q ? S_DONE : S_MAC;
      end
`endif
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      k_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      kc_q    <= '0;
      acc_q   <= '0;
      error_q <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      k_q     <= k_d;
      n_q     <= n_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kc_q    <= kc_d;
      acc_q   <= acc_d;
      error_q <= error_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
    end
  end

`ifdef READBACK_CHECK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rb_addr_q <= '0;
      rb_data_q <= '0;
      rb_pend_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      rb_addr_q <= rb_addr_d;
      rb_data_q <= rb_data_d;
      rb_pend_q <= rb_pend_d;
      last_q    <= last_d;
    end
  end
`endif

  assign error     = error_q;
  assign addr0     = addr0_d;
  assign addr1     = addr1_d;
  assign write_en0 = 1'b0;
  assign write_en1 = 1'b0;
  assign datain0   = '0;
  assign datain1   = '0;
  assign datain3   = '0;
endmodule

// File: tb/tb_matmul_mem_ctrl.sv
// Bench for matmul_mem_ctrl: a 4-port RAM model plus a scoreboard of expected C writes.
module tb_matmul_mem_ctrl;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
`ifdef READBACK_CHECK_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 2;
`endif

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, done, error;
  logic write_en0, write_en1, write_en2, write_en3;
  logic [ADDR_W-1:0] addr0, addr1, addr2, addr3;
  logic [DATA_W-1:0] datain0, datain1, datain2, datain3;
  logic [DATA_W-1:0] dataout0, dataout1, dataout2, dataout3;

  logic              tb_we = 1'b0;
  logic [ADDR_W-1:0] tb_addr = '0;
  logic [DATA_W-1:0] tb_wdata = '0;
  logic              corrupt_rb = 1'b0;

  logic [DATA_W-1:0] ram [256];
  logic [DATA_W-1:0] dout0_q, dout1_q, dout2_q, dout3_q;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  int vectors = 0, miscompares = 0, job_writes = 0;

  always #5 clock = ~clock;

  matmul_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .HDR_BASE(0)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .error(error),
    .write_en0(write_en0), .write_en1(write_en1), .write_en2(write_en2), .write_en3(write_en3),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .datain0(datain0), .datain1(datain1), .datain2(datain2), .datain3(datain3),
    .dataout0(dataout0), .dataout1(dataout1), .dataout2(dataout2), .dataout3(dataout3)
  );

  // Registered-read RAM: data for an address appears the cycle after it is presented.
  always @(posedge clock) begin
    if (tb_we)     ram[tb_addr] <= tb_wdata;
    if (write_en0) ram[addr0] <= datain0;
    if (write_en1) ram[addr1] <= datain1;
    if (write_en2) ram[addr2] <= datain2;
    if (write_en3) ram[addr3] <= datain3;
    dout0_q <= ram[addr0];
    dout1_q <= ram[addr1];
    dout2_q <= ram[addr2];
    dout3_q <= ram[addr3];
  end
  assign dataout0 = dout0_q;
  assign dataout1 = dout1_q;
  assign dataout2 = dout2_q;
  assign dataout3 = dout3_q ^ {{(DATA_W-1){1'b0}}, corrupt_rb};

  // Write monitor: every port-2 write must match the next scoreboard entry.
  always @(negedge clock) begin
    if (reset_n) begin
      if (write_en0 || write_en1 || write_en3) begin
        vectors++;
        miscompares++;
        $display("FAIL stray_write: we0=%b we1=%b we3=%b, required all 0", write_en0, write_en1, write_en3);
      end
      if (write_en2) begin
        wr_t e;
        job_writes++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, no write expected", addr2, datain2);
        end else begin
          e = exp_q.pop_front();
          if (addr2 !== e.a || datain2 !== e.d) begin
            miscompares++;
            $display("FAIL c_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                     addr2, datain2, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic mem_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Loads header and operands; when push is set, also queues the expected C writes.
  task automatic load_job(input int m, input int k, input int n,
                          input logic [DATA_W-1:0] av[$], input logic [DATA_W-1:0] bv[$],
                          input bit push);
    int bb, cb;
    logic [DATA_W-1:0] acc, p;
    mem_write(8'd0, DATA_W'(m));
    mem_write(8'd1, DATA_W'(k));
    mem_write(8'd2, DATA_W'(n));
    bb = 3 + m*k;
    cb = bb + k*n;
    foreach (av[x]) mem_write(ADDR_W'(3 + x), av[x]);
    foreach (bv[x]) mem_write(ADDR_W'(bb + x), bv[x]);
    if (push) begin
      for (int i = 0; i < m; i++)
        for (int j = 0; j < n; j++) begin
          mem_write(ADDR_W'(cb + i*n + j), 16'hDEAD);
          acc = '0;
          for (int kk = 0; kk < k; kk++) begin
            p   = av[i*k + kk] * bv[kk*n + j];
            acc = acc + p;
          end
          exp_q.push_back('{a: ADDR_W'(cb + i*n + j), d: acc});
        end
    end
  endtask

  task automatic run_job(input string name, input int exp_done, input logic exp_err,
                         input int exp_writes, input int restart_at);
    int cyc;
    bit seen;
    cyc = 0;
    seen = 0;
    job_writes = 0;
    @(negedge clock);
    start = 1'b1;
    while (!seen && cyc < 3000) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      start = (cyc == restart_at);
      if (cyc == 1) begin
        vectors++;
        if (busy !== 1'b1 || error !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_start: busy=%b error=%b, required busy=1 error=0", name, busy, error);
        end
      end
      if (done === 1'b1) seen = 1;
    end
    start = 1'b0;
    vectors++;
    if (!seen || cyc != exp_done || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done: seen=%0d cycle=%0d busy=%b, required done in cycle %0d with busy=0",
               name, seen, cyc, busy, exp_done);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || error !== exp_err) begin
      miscompares++;
      $display("FAIL %s_end: done=%b error=%b, required done=0 error=%b", name, done, error, exp_err);
    end
    vectors++;
    if (job_writes != exp_writes || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_writes: got %0d writes, %0d pending, required %0d writes, 0 pending",
               name, job_writes, exp_q.size(), exp_writes);
    end
  endtask

  task automatic load_normal(input bit push);
    load_job(2, 4, 2, '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9},
             '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17}, push);
  endtask

  task automatic check_normal_ram(input string name);
    logic [DATA_W-1:0] want [4];
    want = '{16'd192, 16'd206, 16'd400, 16'd430};
    for (int x = 0; x < 4; x++) begin
      vectors++;
      if (ram[19 + x] !== want[x]) begin
        miscompares++;
        $display("FAIL %s_ram%0d: got %0d, required %0d", name, 19 + x, ram[19 + x], want[x]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({busy, done, error, write_en0, write_en1, write_en2, write_en3} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {busy, done, error, write_en0, write_en1, write_en2, write_en3});
    end
    vectors++;
    if ({addr0, addr1, addr2, addr3, datain0, datain1, datain2, datain3} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%0h/%0h/%0h/%0h datain2=%0h, required all 0",
               addr0, addr1, addr2, addr3, datain2);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_normal();
    load_normal(1'b1);
    run_job("normal", 4 + 4*(4 + EXTRA), 1'b0, 4, 0);
    check_normal_ram("normal");
  endtask

  task automatic test_wrap();
    load_job(1, 1, 1, '{16'h0100}, '{16'h0100}, 1'b1);
    run_job("wrap", 4 + 1*(1 + EXTRA), 1'b0, 1, 0);
    vectors++;
    if (ram[5] !== 16'h0000) begin
      miscompares++;
      $display("FAIL wrap_ram5: got %0h, required 0", ram[5]);
    end
  endtask

  task automatic test_zero_dim();
    load_job(2, 0, 2, '{}, '{}, 1'b0);
    run_job("zero_dim", 4, 1'b1, 0, 0);
    repeat (3) @(negedge clock);
    vectors++;
    if (error !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_dim_hold: error=%b, required 1 until next start", error);
    end
  endtask

  task automatic test_overflow();
    load_job(16, 1, 16, '{}, '{}, 1'b0);
    run_job("overflow", 4, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    load_normal(1'b1);
    run_job("start_busy", 4 + 4*(4 + EXTRA), 1'b0, 4, 6);
    check_normal_ram("start_busy");
  endtask

  task automatic test_reset_mid_job();
    int active;
    load_normal(1'b0);
    job_writes = 0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || addr0 === 8'd0) begin
      miscompares++;
      $display("FAIL mid_job_active: busy=%b addr0=%0d, required busy=1 addr0!=0", busy, addr0);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, write_en2} !== 3'b0 || {addr0, addr1, addr2, datain2} !== 40'd0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b we2=%b addr0=%0d addr1=%0d, required all 0",
               busy, write_en2, addr0, addr1);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    active = 0;
    repeat (40) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) active++;
    end
    vectors++;
    if (active != 0 || job_writes != 0) begin
      miscompares++;
      $display("FAIL post_reset_idle: active cycles=%0d writes=%0d, required 0 0", active, job_writes);
    end
  endtask

`ifdef READBACK_CHECK_EN
  task automatic test_readback_mismatch();
    corrupt_rb = 1'b1;
    load_normal(1'b1);
    run_job("rb_mismatch", 4 + 4*(4 + EXTRA), 1'b1, 4, 0);
    corrupt_rb = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_normal();
    test_wrap();
    test_zero_dim();
    test_overflow();
    test_back_to_back();
    test_reset_mid_job();
    test_normal();
`ifdef READBACK_CHECK_EN
    test_readback_mismatch();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
